// File: rtl/uart_stop_check.sv
// Stop-field checker for the UART receiver: 3-sample majority vote per stop bit,
// 1 or 2 stop bits, break detection and a saturating stop-error counter.
module uart_stop_check #(
  parameter int PRESCALE_W = 6,
  parameter int CNT_W      = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  stp_chk_en,
  input  logic                  stp_num,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic                  rx_in,
  input  logic                  data_zero,
  input  logic                  err_cnt_clr,
  output logic                  stp_err,
  output logic                  stp_done,
  output logic                  brk_det,
  output logic [CNT_W-1:0]      err_cnt
);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  state_t state_reg, state_next;

  logic [PRESCALE_W-1:0] ps_reg, ps_next;
  logic                  num_reg, num_next;
  logic                  bit_idx_reg, bit_idx_next;
  logic                  s0_reg, s0_next;
  logic                  s1_reg, s1_next;
  logic                  err_reg, err_next;
  logic                  az_reg, az_next;
  logic                  done_reg, done_next;
  logic                  brk_reg, brk_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;

  logic [PRESCALE_W-1:0] mid;
  logic at_s0, at_s1, at_vote, at_end, last_bit;
  logic vote, in_check, start, err_final, az_final, brk_final;

  assign mid      = ps_reg >> 1;
  assign at_s0    = (edge_cnt == mid - PRESCALE_W'(1));
  assign at_s1    = (edge_cnt == mid);
  assign at_vote  = (edge_cnt == mid + PRESCALE_W'(1));
  assign at_end   = (edge_cnt == ps_reg - PRESCALE_W'(1));
  assign last_bit = (bit_idx_reg == num_reg);
  assign vote     = (s0_reg & s1_reg) | (s0_reg & rx_in) | (s1_reg & rx_in);
  assign in_check = (state_reg == CHECK);

  // A new frame may also start straight out of DONE when the next stop field follows immediately.
  assign start = stp_chk_en &&
                 ((state_reg == IDLE) || ((state_reg == DONE) && (edge_cnt == '0)));

  // The vote may land on the same edge as the bit end (prescale = 4), so fold it in here.
  assign err_final = err_reg | (at_vote & ~vote);
  assign az_final  = az_reg & ~(at_vote & vote);
  assign brk_final = az_final & data_zero;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (stp_chk_en) state_next = CHECK;
      CHECK: begin
        if (!stp_chk_en)          state_next = IDLE;
        else if (at_end && last_bit) state_next = DONE;
      end
      DONE:    state_next = start ? CHECK : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ps_next      = ps_reg;
    num_next     = num_reg;
    bit_idx_next = bit_idx_reg;
    s0_next      = s0_reg;
    s1_next      = s1_reg;
    err_next     = err_reg;
    az_next      = az_reg;
    done_next    = 1'b0;
    brk_next     = 1'b0;
    cnt_next     = cnt_reg;

    if (start) begin
      ps_next      = prescale;
      num_next     = stp_num;
      bit_idx_next = 1'b0;
      err_next     = 1'b0;
      az_next      = 1'b1;
    end

    if (in_check) begin
      if (!stp_chk_en) begin
        err_next     = 1'b0;
        bit_idx_next = 1'b0;
      end else begin
        if (at_s0) s0_next = rx_in;
        if (at_s1) s1_next = rx_in;
        err_next = err_final;
        az_next  = az_final;
        if (at_end) begin
          if (last_bit) begin
            done_next = 1'b1;
            brk_next  = brk_final;
            if (err_final && !brk_final && (cnt_reg != {CNT_W{1'b1}}))
              cnt_next = cnt_reg + CNT_W'(1);
          end else begin
            bit_idx_next = 1'b1;
          end
        end
      end
    end

    if (err_cnt_clr) cnt_next = '0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ps_reg      <= '0;
      num_reg     <= 1'b0;
      bit_idx_reg <= 1'b0;
      s0_reg      <= 1'b0;
      s1_reg      <= 1'b0;
      err_reg     <= 1'b0;
      az_reg      <= 1'b0;
      done_reg    <= 1'b0;
      brk_reg     <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      ps_reg      <= ps_next;
      num_reg     <= num_next;
      bit_idx_reg <= bit_idx_next;
      s0_reg      <= s0_next;
      s1_reg      <= s1_next;
      err_reg     <= err_next;
      az_reg      <= az_next;
      done_reg    <= done_next;
      brk_reg     <= brk_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign stp_err  = err_reg;
  assign stp_done = done_reg;
  assign brk_det  = brk_reg;
  assign err_cnt  = cnt_reg;

endmodule

// File: tb/tb_uart_stop_check.sv
// Directed bench for uart_stop_check; a second instance with a 2-bit counter
// shares the stimulus to exercise counter saturation.
module tb_uart_stop_check;

  logic       clk;
  logic       rst_n;
  logic       stp_chk_en;
  logic       stp_num;
  logic [5:0] prescale;
  logic [5:0] edge_cnt;
  logic       rx_in;
  logic       data_zero;
  logic       err_cnt_clr;
  logic       stp_err, stp_done, brk_det;
  logic [7:0] err_cnt;
  logic       sat_err, sat_done, sat_brk;
  logic [1:0] sat_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  int   n_done, done_at, last_done_at, err_at, n_brk;
  logic err_at_done, brk_at_done, err_obs_abort;
  logic [7:0] cnt_at_done;

  uart_stop_check #(.PRESCALE_W(6), .CNT_W(8)) dut (
    .CLK(clk), .RST(rst_n), .stp_chk_en(stp_chk_en), .stp_num(stp_num),
    .prescale(prescale), .edge_cnt(edge_cnt), .rx_in(rx_in), .data_zero(data_zero),
    .err_cnt_clr(err_cnt_clr), .stp_err(stp_err), .stp_done(stp_done),
    .brk_det(brk_det), .err_cnt(err_cnt)
  );

  uart_stop_check #(.PRESCALE_W(6), .CNT_W(2)) dut_sat (
    .CLK(clk), .RST(rst_n), .stp_chk_en(stp_chk_en), .stp_num(stp_num),
    .prescale(prescale), .edge_cnt(edge_cnt), .rx_in(rx_in), .data_zero(data_zero),
    .err_cnt_clr(err_cnt_clr), .stp_err(sat_err), .stp_done(sat_done),
    .brk_det(sat_brk), .err_cnt(sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then look at the registered response just after the edge.
  task automatic step(input logic en, input int e, input logic rx);
    stp_chk_en = en;
    edge_cnt   = 6'(e);
    rx_in      = rx;
    @(posedge clk);
    #1;
  endtask

  // Runs one stop field; rx_in is low on edges lo_s..lo_e of the bits set in lo_mask.
  task automatic run_frame(input int ps, input logic num, input logic [1:0] lo_mask,
                           input int lo_s, input int lo_e, input logic dz,
                           input int abort_at, input int clr_at);
    int   total;
    int   b;
    int   e;
    logic en_v;
    logic rx_v;
    total = num ? 2 * ps : ps;
    prescale  = 6'(ps);
    stp_num   = num;
    data_zero = dz;
    n_done = 0; done_at = -1; last_done_at = -1; err_at = -1; n_brk = 0;
    err_at_done = 1'b0; brk_at_done = 1'b0; cnt_at_done = '0; err_obs_abort = 1'bx;
    for (int i = 0; i < total + 3; i++) begin
      b = i / ps;
      e = i % ps;
      en_v = (i < total) && ((abort_at < 0) || (i < abort_at));
      rx_v = 1'b1;
      if (i < total) begin
        if (lo_mask[b] && (e >= lo_s) && (e <= lo_e)) rx_v = 1'b0;
      end
      err_cnt_clr = (i == clr_at);
      step(en_v, en_v ? e : 0, rx_v);
      if (stp_done) begin
        n_done++;
        last_done_at = i;
        if (done_at < 0) begin
          done_at = i; err_at_done = stp_err; brk_at_done = brk_det; cnt_at_done = err_cnt;
        end
      end
      if (brk_det) n_brk++;
      if (stp_err && (err_at < 0)) err_at = i;
      if (i == abort_at) err_obs_abort = stp_err;
    end
    err_cnt_clr = 1'b0;
    $display("frame ps=%0d num=%0d dz=%0d: done=%0d@%0d err@%0d brk=%0d cnt=%0d sat=%0d",
             ps, num, dz, n_done, done_at, err_at, n_brk, err_cnt, sat_cnt);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (stp_err !== 1'b0)  begin n_bad++; $display("FAIL reset_err: got %b expected 0", stp_err); end
    n_cmp++; if (stp_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", stp_done); end
    n_cmp++; if (brk_det !== 1'b0)  begin n_bad++; $display("FAIL reset_brk: got %b expected 0", brk_det); end
    n_cmp++; if (err_cnt !== 8'd0)  begin n_bad++; $display("FAIL reset_cnt: got %0d expected 0", err_cnt); end
    rst_n = 1'b1;
    step(1'b0, 0, 1'b1);
    $display("reset released");
  endtask

  task automatic test_good();
    run_frame(8, 1'b0, 2'b00, 0, 0, 1'b0, -1, -1);
    n_cmp++; if (n_done !== 1)    begin n_bad++; $display("FAIL good_ndone: got %0d expected 1", n_done); end
    n_cmp++; if (done_at !== 7)   begin n_bad++; $display("FAIL good_done_at: got %0d expected 7", done_at); end
    n_cmp++; if (err_at !== -1)   begin n_bad++; $display("FAIL good_err: got %0d expected -1", err_at); end
    n_cmp++; if (n_brk !== 0)     begin n_bad++; $display("FAIL good_brk: got %0d expected 0", n_brk); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL good_cnt: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_glitch();
    run_frame(8, 1'b0, 2'b01, 4, 4, 1'b0, -1, -1);
    n_cmp++; if (err_at !== -1)    begin n_bad++; $display("FAIL glitch_err: got %0d expected -1", err_at); end
    n_cmp++; if (n_done !== 1)     begin n_bad++; $display("FAIL glitch_ndone: got %0d expected 1", n_done); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL glitch_cnt: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_error();
    run_frame(8, 1'b0, 2'b01, 3, 5, 1'b0, -1, -1);
    n_cmp++; if (err_at !== 5)         begin n_bad++; $display("FAIL error_err_at: got %0d expected 5", err_at); end
    n_cmp++; if (done_at !== 7)        begin n_bad++; $display("FAIL error_done_at: got %0d expected 7", done_at); end
    n_cmp++; if (cnt_at_done !== 8'd1) begin n_bad++; $display("FAIL error_cnt_at_done: got %0d expected 1", cnt_at_done); end
    n_cmp++; if (err_cnt !== 8'd1)     begin n_bad++; $display("FAIL error_cnt: got %0d expected 1", err_cnt); end
    n_cmp++; if (stp_err !== 1'b1)     begin n_bad++; $display("FAIL error_hold: got %b expected 1", stp_err); end
  endtask

  task automatic test_two_stop();
    run_frame(16, 1'b1, 2'b10, 7, 9, 1'b0, -1, -1);
    n_cmp++; if (err_at !== 25)    begin n_bad++; $display("FAIL two_err_at: got %0d expected 25", err_at); end
    n_cmp++; if (n_done !== 1)     begin n_bad++; $display("FAIL two_ndone: got %0d expected 1", n_done); end
    n_cmp++; if (done_at !== 31)   begin n_bad++; $display("FAIL two_done_at: got %0d expected 31", done_at); end
    n_cmp++; if (err_cnt !== 8'd2) begin n_bad++; $display("FAIL two_cnt: got %0d expected 2", err_cnt); end
  endtask

  task automatic test_break();
    run_frame(8, 1'b0, 2'b01, 0, 7, 1'b1, -1, -1);
    n_cmp++; if (brk_at_done !== 1'b1) begin n_bad++; $display("FAIL brk_det: got %b expected 1", brk_at_done); end
    n_cmp++; if (err_at_done !== 1'b1) begin n_bad++; $display("FAIL brk_err: got %b expected 1", err_at_done); end
    n_cmp++; if (n_brk !== 1)          begin n_bad++; $display("FAIL brk_pulses: got %0d expected 1", n_brk); end
    n_cmp++; if (done_at !== 7)        begin n_bad++; $display("FAIL brk_done_at: got %0d expected 7", done_at); end
    n_cmp++; if (err_cnt !== 8'd2)     begin n_bad++; $display("FAIL brk_cnt: got %0d expected 2", err_cnt); end
    data_zero = 1'b0;
  endtask

  task automatic test_abort();
    run_frame(8, 1'b1, 2'b01, 3, 5, 1'b0, 14, -1);
    n_cmp++; if (err_at !== 5)          begin n_bad++; $display("FAIL abort_err_at: got %0d expected 5", err_at); end
    n_cmp++; if (err_obs_abort !== 1'b0) begin n_bad++; $display("FAIL abort_err_clr: got %b expected 0", err_obs_abort); end
    n_cmp++; if (n_done !== 0)          begin n_bad++; $display("FAIL abort_ndone: got %0d expected 0", n_done); end
    n_cmp++; if (err_cnt !== 8'd2)      begin n_bad++; $display("FAIL abort_cnt: got %0d expected 2", err_cnt); end
  endtask

  task automatic test_clear();
    run_frame(8, 1'b0, 2'b01, 3, 5, 1'b0, -1, 7);
    n_cmp++; if (n_done !== 1)         begin n_bad++; $display("FAIL clr_ndone: got %0d expected 1", n_done); end
    n_cmp++; if (cnt_at_done !== 8'd0) begin n_bad++; $display("FAIL clr_cnt_at_done: got %0d expected 0", cnt_at_done); end
    n_cmp++; if (err_cnt !== 8'd0)     begin n_bad++; $display("FAIL clr_cnt: got %0d expected 0", err_cnt); end
    n_cmp++; if (sat_cnt !== 2'd0)     begin n_bad++; $display("FAIL clr_sat_cnt: got %0d expected 0", sat_cnt); end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 4; k++) run_frame(8, 1'b0, 2'b01, 3, 5, 1'b0, -1, -1);
    n_cmp++; if (sat_cnt !== 2'd3) begin n_bad++; $display("FAIL sat_cnt: got %0d expected 3", sat_cnt); end
    n_cmp++; if (err_cnt !== 8'd4) begin n_bad++; $display("FAIL sat_wide_cnt: got %0d expected 4", err_cnt); end
  endtask

  task automatic test_back_to_back();
    int   dones;
    int   first_err;
    logic err_s7, err_s8, err_s15;
    logic [1:0] done_mask;
    prescale = 6'd8; stp_num = 1'b0; data_zero = 1'b0;
    dones = 0; first_err = -1; done_mask = '0;
    err_s7 = 1'bx; err_s8 = 1'bx; err_s15 = 1'bx;
    for (int i = 0; i < 18; i++) begin
      step(i < 16, (i < 16) ? (i % 8) : 0, !((i >= 3) && (i <= 5)));
      if (stp_done) begin
        dones++;
        if (i == 7)  done_mask[0] = 1'b1;
        if (i == 15) done_mask[1] = 1'b1;
      end
      if (stp_err && (first_err < 0)) first_err = i;
      if (i == 7)  err_s7  = stp_err;
      if (i == 8)  err_s8  = stp_err;
      if (i == 15) err_s15 = stp_err;
    end
    $display("back_to_back: dones=%0d mask=%b err@%0d cnt=%0d", dones, done_mask, first_err, err_cnt);
    n_cmp++; if (dones !== 2)          begin n_bad++; $display("FAIL b2b_ndone: got %0d expected 2", dones); end
    n_cmp++; if (done_mask !== 2'b11)  begin n_bad++; $display("FAIL b2b_done_pos: got %b expected 11", done_mask); end
    n_cmp++; if (first_err !== 5)      begin n_bad++; $display("FAIL b2b_err_at: got %0d expected 5", first_err); end
    n_cmp++; if (err_s7 !== 1'b1)      begin n_bad++; $display("FAIL b2b_err_a: got %b expected 1", err_s7); end
    n_cmp++; if (err_s8 !== 1'b0)      begin n_bad++; $display("FAIL b2b_err_restart: got %b expected 0", err_s8); end
    n_cmp++; if (err_s15 !== 1'b0)     begin n_bad++; $display("FAIL b2b_err_b: got %b expected 0", err_s15); end
    n_cmp++; if (err_cnt !== 8'd5)     begin n_bad++; $display("FAIL b2b_cnt: got %0d expected 5", err_cnt); end
  endtask

  task automatic test_reset_mid();
    int dones;
    prescale = 6'd8; stp_num = 1'b0;
    for (int i = 0; i < 7; i++) step(1'b1, i, !((i >= 3) && (i <= 5)));
    n_cmp++; if (stp_err !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_err: got %b expected 1", stp_err); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (stp_err !== 1'b0)  begin n_bad++; $display("FAIL rmid_err: got %b expected 0", stp_err); end
    n_cmp++; if (stp_done !== 1'b0) begin n_bad++; $display("FAIL rmid_done: got %b expected 0", stp_done); end
    n_cmp++; if (brk_det !== 1'b0)  begin n_bad++; $display("FAIL rmid_brk: got %b expected 0", brk_det); end
    n_cmp++; if (err_cnt !== 8'd0)  begin n_bad++; $display("FAIL rmid_cnt: got %0d expected 0", err_cnt); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, (i == 0) ? 7 : 0, 1'b1);
      if (stp_done) dones++;
    end
    $display("reset mid-frame: dones after release=%0d", dones);
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL rmid_ndone: got %0d expected 0", dones); end
  endtask

  initial begin
    rst_n = 1'b0; stp_chk_en = 1'b0; stp_num = 1'b0; prescale = 6'd8;
    edge_cnt = '0; rx_in = 1'b1; data_zero = 1'b0; err_cnt_clr = 1'b0;
    test_reset();
    test_good();
    test_glitch();
    test_error();
    test_two_stop();
    test_break();
    test_abort();
    test_clear();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
